div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Sequential signed 32-bit divider; responder to the control unit's DivCtrl request.
//   The control unit pulses div_start in state_div, then polls in wait4 for done or div_zero.
//   On done, Hi/Lo are captured; on div_zero it branches to state_divzero1.
//   Restoring algorithm, one quotient bit per cycle. Hi = remainder, Lo = quotient (MIPS DIV semantics).
// PARAMETERS
//   WIDTH      32   operand/result width; counter width is $clog2(WIDTH)+1
// PORTS
//   clk        in   1      system clock; all state changes on rising edge
//   reset      in   1      asynchronous, active-low reset
//   div_start  in   1      one-cycle request (control-unit DivCtrl); accepted only in IDLE
//   dividend   in   WIDTH  signed dividend (register A); sampled on the accepting edge
//   divisor    in   WIDTH  signed divisor (register B); sampled on the accepting edge
//   hi_out     out  WIDTH  remainder of the last successful division
//   lo_out     out  WIDTH  quotient of the last successful division
//   div_zero   out  1      one-cycle pulse: request had divisor == 0
//   done       out  1      one-cycle pulse: request finished (success or div_zero)
//   busy       out  1      high while a division is in flight (RUN/FIX)
// BEHAVIOUR
//   Reset (reset==0, asynchronous):
//     - state=IDLE; hi_out, lo_out, div_zero, done, busy = 0; all internal registers = 0.
//     - Reset mid-operation aborts the division; no done pulse is produced.
//   FSM states: IDLE, RUN, FIX.
//   IDLE, div_start=1, divisor==0 (edge E0):
//     - div_zero=1, done=1 for the next cycle only; hi_out/lo_out unchanged.
//     - State stays IDLE.
//   IDLE, div_start=1, divisor!=0 (edge E0):
//     - Latch |dividend| and |divisor| as unsigned WIDTH-bit values.
//     - Latch sign_q = sign(dividend) XOR sign(divisor); sign_r = sign(dividend).
//     - rem (WIDTH+1 bits) = 0; cnt = 0; busy=1; go to RUN.
//   RUN (edges E1..E32):
//     - Shift {rem,quot} left 1, bringing in the dividend MSB.
//     - If rem >= |divisor|: rem -= |divisor| and set quot LSB = 1; otherwise quot LSB = 0.
//     - cnt++; after the WIDTH-th iteration, go to FIX.
//   FIX (edge E33):
//     - lo_out = sign_q ? -quot : quot; hi_out = sign_r ? -rem : rem (mod 2^WIDTH).
//     - done=1 for one cycle; busy=0; go to IDLE.
//   Latency:
//     - Normal: done is high in the cycle following E33, i.e. WIDTH+1 edges after acceptance.
//     - Zero divisor: done is high in the cycle following E0.
//   Truncating division: quotient rounds toward zero; remainder takes the sign of the dividend.
//   Boundaries:
//     - 0x80000000 / 0xFFFFFFFF wraps: lo_out=0x80000000, hi_out=0; no flag.
//     - Dividend 0 with nonzero divisor: lo_out=0, hi_out=0, full latency.
//     - |dividend| < |divisor|: lo_out=0, hi_out=dividend.
//   div_start while busy:
//     - Ignored; no queuing; operands are not resampled.
//   div_start during a done-pulse cycle:
//     - FSM is already in IDLE, so the request is accepted.
//   done and div_zero are never high together with busy.
//   hi_out/lo_out change only on the FIX edge or on reset.
// TESTING
//   - 100 / 7 -> done exactly 33 edges after start; lo_out=14, hi_out=2; busy high for 33 cycles.
//   - -100 / 7 -> lo_out=0xFFFFFFF2 (-14), hi_out=0xFFFFFFFE (-2); 100 / -7 -> lo_out=-14, hi_out=2.
//   - Prior result 14/2, then 5 / 0 -> div_zero=done=1 for 1 cycle after E0; hi_out=2, lo_out=14 kept.
//   - 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_zero=0.
//   - div_start pulses at E5 with new operands during a 100/7 run -> ignored; result still 14/2, one done.
//   - Reset asserted at E10 of a run -> outputs 0 immediately, no done; next 9/3 gives lo=3, hi=0.

Source files
------------

// File: rtl/div_unit.sv
// Sequential signed divider, restoring algorithm, one quotient bit per clock.
// Results follow MIPS DIV: hi_out = remainder, lo_out = quotient, truncating toward zero.
//
// state | meaning
// IDLE  | waiting for div_start; zero-divisor requests are answered here
// RUN   | WIDTH restoring iterations on the operand magnitudes
// FIX   | apply signs, publish hi_out/lo_out, pulse done
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] quot, quot_nxt;
    logic [WIDTH-1:0] dvs, dvs_nxt;
    logic [WIDTH:0]   rem, rem_nxt, rem_sh;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             sign_q, sign_q_nxt;
    logic             sign_r, sign_r_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             div_zero_nxt, done_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            quot     <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            quot     <= quot_nxt;
            dvs      <= dvs_nxt;
            rem      <= rem_nxt;
            cnt      <= cnt_nxt;
            sign_q   <= sign_q_nxt;
            sign_r   <= sign_r_nxt;
            hi_out   <= hi_nxt;
            lo_out   <= lo_nxt;
            div_zero <= div_zero_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        quot_nxt     = quot;
        dvs_nxt      = dvs;
        rem_nxt      = rem;
        cnt_nxt      = cnt;
        sign_q_nxt   = sign_q;
        sign_r_nxt   = sign_r;
        hi_nxt       = hi_out;
        lo_nxt       = lo_out;
        div_zero_nxt = 1'b0;
        done_nxt     = 1'b0;
        // quot doubles as the dividend shift register: its MSB feeds the remainder
        rem_sh       = {rem[WIDTH-1:0], quot[WIDTH-1]};

        case (state)
            IDLE: begin
                if (div_start) begin
                    if (divisor == '0) begin
                        div_zero_nxt = 1'b1;
                        done_nxt     = 1'b1;
                    end else begin
                        quot_nxt   = dividend[WIDTH-1] ? -dividend : dividend;
                        dvs_nxt    = divisor[WIDTH-1] ? -divisor : divisor;
                        sign_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_nxt = dividend[WIDTH-1];
                        rem_nxt    = '0;
                        cnt_nxt    = '0;
                        state_nxt  = RUN;
                    end
                end
            end
            RUN: begin
                if (rem_sh >= {1'b0, dvs}) begin
                    rem_nxt  = rem_sh - {1'b0, dvs};
                    quot_nxt = {quot[WIDTH-2:0], 1'b1};
                end else begin
                    rem_nxt  = rem_sh;
                    quot_nxt = {quot[WIDTH-2:0], 1'b0};
                end
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1))
                    state_nxt = FIX;
            end
            FIX: begin
                lo_nxt    = sign_q ? -quot : quot;
                hi_nxt    = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
